// File: rtl/sta_ram_pkg.sv
// Shared types and helpers for the statistics-counter RAM controller.
package sta_ram_pkg;

    // Controller phases: zero sweep, then normal traffic.
    typedef enum logic {
        INIT,
        RUN
    } state_e;

    // Which requester owned the most recent grant.
    typedef enum logic {
        EVT,
        HOST
    } gnt_e;

    // Widest counter the adder helper supports. DATA_WIDTH above this is not allowed.
    localparam int unsigned SUM_MAX_W = 64;

    typedef struct packed {
        logic                 ovf;
        logic [SUM_MAX_W-1:0] sum;
    } add_res_t;

    // Add two zero-extended operands at an arbitrary width up to SUM_MAX_W.
    // The overflow flag is the carry out of bit 'width'. Saturation clamps to
    // all-ones at that width; otherwise the sum wraps.
    function automatic add_res_t sat_add(
        input logic [SUM_MAX_W-1:0] a,
        input logic [SUM_MAX_W-1:0] b,
        input logic [6:0]           width,
        input logic                 saturate
    );
        logic [SUM_MAX_W:0]   full;
        logic [SUM_MAX_W-1:0] mask;
        add_res_t             res;
        full    = {1'b0, a} + {1'b0, b};
        mask    = {SUM_MAX_W{1'b1}} >> (SUM_MAX_W - width);
        res.ovf = full[width];
        res.sum = (res.ovf && saturate) ? mask : (full[SUM_MAX_W-1:0] & mask);
        return res;
    endfunction

endpackage

// File: rtl/sta_ram_ctrl_ram.sv
// Simple dual-port distributed RAM used for the counter storage.
// Read is combinational when OUT_REG=0; optional output register otherwise.
module ipm_distributed_sdpram_v1_3_ram_data_sta #(
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned DATA_WIDTH = 32,
    parameter string       RST_TYPE   = "ASYNC",
    parameter int unsigned OUT_REG    = 0,
    parameter string       INIT_FILE  = "NONE"
) (
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic                  wr_en,
    input  logic                  wr_clk,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic                  rd_clk,
    input  logic                  rst,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int unsigned DEPTH     = 1 << ADDR_WIDTH;
    localparam bit          ASYNC_RST = (RST_TYPE == "ASYNC");
    // Preloading from a file is not supported; contents start undefined.
    localparam bit          HAS_INIT  = (INIT_FILE != "NONE");

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  unused_ok;

    // Write port: one word per cycle when enabled.
    // NOTE: the storage array has no reset; clearing it is the controller's sweep, not a reset net.
    always_ff @(posedge wr_clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    generate
        if (OUT_REG == 0) begin : g_comb_rd
            assign rd_data   = mem[rd_addr];
            assign unused_ok = ^{rst, rd_clk, HAS_INIT, ASYNC_RST};
        end else if (ASYNC_RST) begin : g_reg_async
            logic [DATA_WIDTH-1:0] rd_q;
            // Registered read with asynchronous reset of the output only.
            always_ff @(posedge rd_clk or posedge rst) begin
                if (rst) begin
                    rd_q <= '0;
                end else begin
                    rd_q <= mem[rd_addr];
                end
            end
            assign rd_data   = rd_q;
            assign unused_ok = HAS_INIT;
        end else begin : g_reg_sync
            logic [DATA_WIDTH-1:0] rd_q;
            // Registered read with synchronous reset of the output only.
            always_ff @(posedge rd_clk) begin
                if (rst) begin
                    rd_q <= '0;
                end else begin
                    rd_q <= mem[rd_addr];
                end
            end
            assign rd_data   = rd_q;
            assign unused_ok = HAS_INIT;
        end
    endgenerate

endmodule

// File: rtl/sta_ram_ctrl.sv
// Statistics counter controller: zero sweep after reset/soft_clr, then
// round-robin arbitration between datapath increments and host reads,
// each serviced as a single-cycle read-modify-write on the counter RAM.
module sta_ram_ctrl
    import sta_ram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned INC_WIDTH  = 8,
    parameter int unsigned SATURATE   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  soft_clr,
    output logic                  init_done,
    input  logic                  evt_vld,
    output logic                  evt_rdy,
    input  logic [ADDR_WIDTH-1:0] evt_addr,
    input  logic [INC_WIDTH-1:0]  evt_inc,
    input  logic                  host_vld,
    output logic                  host_rdy,
    input  logic [ADDR_WIDTH-1:0] host_addr,
    input  logic                  host_clr,
    output logic                  host_rd_vld,
    output logic [DATA_WIDTH-1:0] host_rd_data,
    output logic                  ovf_pulse,
    output logic [ADDR_WIDTH-1:0] ovf_addr
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    gnt_e                  last_gnt_q, last_gnt_d;
    logic                  init_done_q, init_done_d;
    logic                  host_rd_vld_q, host_rd_vld_d;
    logic [DATA_WIDTH-1:0] host_rd_data_q, host_rd_data_d;
    logic                  ovf_pulse_q, ovf_pulse_d;
    logic [ADDR_WIDTH-1:0] ovf_addr_q, ovf_addr_d;

    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_wa;
    logic [DATA_WIDTH-1:0] ram_wd;
    logic [ADDR_WIDTH-1:0] ram_ra;
    logic [DATA_WIDTH-1:0] ram_q;

    logic                  accept;
    logic                  evt_gnt;
    logic                  host_gnt;
    add_res_t              add_res;
    logic                  unused_add_hi;

    // Traffic is only accepted in RUN, and never in a soft_clr cycle.
    assign accept = (state_q == RUN) && !soft_clr;

    // Each ready looks only at the other requester's valid and the last grant,
    // so under contention the grant alternates and the two readies are exclusive.
    assign evt_rdy  = accept && (!host_vld || (last_gnt_q == HOST));
    assign host_rdy = accept && (!evt_vld || (last_gnt_q == EVT));
    assign evt_gnt  = evt_vld && evt_rdy;
    assign host_gnt = host_vld && host_rdy;

    // Counter update: current value plus zero-extended increment.
    assign add_res = sat_add(SUM_MAX_W'(ram_q), SUM_MAX_W'(evt_inc), 7'(DATA_WIDTH),
                             SATURATE != 0);
    assign unused_add_hi = ^add_res;

    // RAM port steering: sweep writes, increment write-back, or clear-on-read.
    // NOTE: every output of a combinational block gets a default first, so no path leaves a latch.
    always_comb begin
        ram_we = 1'b0;
        ram_wa = evt_addr;
        ram_wd = '0;
        ram_ra = host_gnt ? host_addr : evt_addr;
        if (state_q == INIT) begin
            ram_we = 1'b1;
            ram_wa = ptr_q;
        end else if (evt_gnt) begin
            ram_we = 1'b1;
            ram_wa = evt_addr;
            ram_wd = add_res.sum[DATA_WIDTH-1:0];
        end else if (host_gnt && host_clr) begin
            ram_we = 1'b1;
            ram_wa = host_addr;
        end
    end

    // FSM next state, sweep pointer and round-robin history.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        last_gnt_d = last_gnt_q;
        if (soft_clr) begin
            state_d    = INIT;
            ptr_d      = '0;
            last_gnt_d = HOST;
        end else if (state_q == INIT) begin
            // HOST as the last grant gives events first priority after a sweep.
            last_gnt_d = HOST;
            if (ptr_q == LAST_ADDR) begin
                state_d = RUN;
                ptr_d   = '0;
            end else begin
                ptr_d = ptr_q + 1'b1;
            end
        end else if (evt_gnt) begin
            last_gnt_d = EVT;
        end else if (host_gnt) begin
            last_gnt_d = HOST;
        end
    end

    // Registered outputs: host read return, overflow report, init status.
    // A host read granted just before soft_clr still completes here.
    always_comb begin
        init_done_d    = (state_d == RUN);
        host_rd_vld_d  = host_gnt;
        host_rd_data_d = host_gnt ? ram_q : host_rd_data_q;
        ovf_pulse_d    = evt_gnt && add_res.ovf;
        ovf_addr_d     = ovf_pulse_d ? evt_addr : ovf_addr_q;
    end

    // State and output registers.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= INIT;
            ptr_q          <= '0;
            last_gnt_q     <= HOST;
            init_done_q    <= 1'b0;
            host_rd_vld_q  <= 1'b0;
            host_rd_data_q <= '0;
            ovf_pulse_q    <= 1'b0;
            ovf_addr_q     <= '0;
        end else begin
            state_q        <= state_d;
            ptr_q          <= ptr_d;
            last_gnt_q     <= last_gnt_d;
            init_done_q    <= init_done_d;
            host_rd_vld_q  <= host_rd_vld_d;
            host_rd_data_q <= host_rd_data_d;
            ovf_pulse_q    <= ovf_pulse_d;
            ovf_addr_q     <= ovf_addr_d;
        end
    end

    assign init_done    = init_done_q;
    assign host_rd_vld  = host_rd_vld_q;
    assign host_rd_data = host_rd_data_q;
    assign ovf_pulse    = ovf_pulse_q;
    assign ovf_addr     = ovf_addr_q;

    ipm_distributed_sdpram_v1_3_ram_data_sta #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .RST_TYPE   ("ASYNC"),
        .OUT_REG    (0),
        .INIT_FILE  ("NONE")
    ) u_ram (
        .wr_data (ram_wd),
        .wr_addr (ram_wa),
        .wr_en   (ram_we),
        .wr_clk  (clk),
        .rd_addr (ram_ra),
        .rd_clk  (clk),
        .rst     (~rst_n),
        .rd_data (ram_q)
    );

endmodule

// File: tb/tb_sta_ram_ctrl.sv
// Directed bench for sta_ram_ctrl. Three instances share one stimulus:
// the default 32-bit saturating build, and 12-bit saturating / wrapping
// builds whose overflow boundary is reachable with 8-bit increments.
`timescale 1ns/1ps
module tb_sta_ram_ctrl;

    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          soft_clr = 1'b0;
    logic          evt_vld = 1'b0;
    logic [AW-1:0] evt_addr = '0;
    logic [7:0]    evt_inc = '0;
    logic          host_vld = 1'b0;
    logic [AW-1:0] host_addr = '0;
    logic          host_clr = 1'b0;

    logic          init_done, evt_rdy, host_rdy, host_rd_vld, ovf_pulse;
    logic [31:0]   host_rd_data;
    logic [AW-1:0] ovf_addr;
    logic          s_init_done, s_evt_rdy, s_host_rdy, s_host_rd_vld, s_ovf_pulse;
    logic [11:0]   s_host_rd_data;
    logic [AW-1:0] s_ovf_addr;
    logic          w_init_done, w_evt_rdy, w_host_rdy, w_host_rd_vld, w_ovf_pulse;
    logic [11:0]   w_host_rd_data;
    logic [AW-1:0] w_ovf_addr;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    sta_ram_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(32), .INC_WIDTH(8), .SATURATE(1)) dut (
        .clk(clk), .rst_n(rst_n), .soft_clr(soft_clr), .init_done(init_done),
        .evt_vld(evt_vld), .evt_rdy(evt_rdy), .evt_addr(evt_addr), .evt_inc(evt_inc),
        .host_vld(host_vld), .host_rdy(host_rdy), .host_addr(host_addr), .host_clr(host_clr),
        .host_rd_vld(host_rd_vld), .host_rd_data(host_rd_data),
        .ovf_pulse(ovf_pulse), .ovf_addr(ovf_addr)
    );

    sta_ram_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(12), .INC_WIDTH(8), .SATURATE(1)) dut_s12 (
        .clk(clk), .rst_n(rst_n), .soft_clr(soft_clr), .init_done(s_init_done),
        .evt_vld(evt_vld), .evt_rdy(s_evt_rdy), .evt_addr(evt_addr), .evt_inc(evt_inc),
        .host_vld(host_vld), .host_rdy(s_host_rdy), .host_addr(host_addr), .host_clr(host_clr),
        .host_rd_vld(s_host_rd_vld), .host_rd_data(s_host_rd_data),
        .ovf_pulse(s_ovf_pulse), .ovf_addr(s_ovf_addr)
    );

    sta_ram_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(12), .INC_WIDTH(8), .SATURATE(0)) dut_w12 (
        .clk(clk), .rst_n(rst_n), .soft_clr(soft_clr), .init_done(w_init_done),
        .evt_vld(evt_vld), .evt_rdy(w_evt_rdy), .evt_addr(evt_addr), .evt_inc(evt_inc),
        .host_vld(host_vld), .host_rdy(w_host_rdy), .host_addr(host_addr), .host_clr(host_clr),
        .host_rd_vld(w_host_rd_vld), .host_rd_data(w_host_rd_data),
        .ovf_pulse(w_ovf_pulse), .ovf_addr(w_ovf_addr)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One event handshake; evt_vld is left high so calls chain back-to-back.
    task automatic do_evt(input logic [AW-1:0] a, input logic [7:0] inc);
        evt_vld  = 1'b1;
        evt_addr = a;
        evt_inc  = inc;
        #1;
        check($sformatf("evt_rdy[%0d]", a), evt_rdy, 1'b1);
        tick();
    endtask

    // One host handshake, then check the data returned one cycle later.
    task automatic host_rd(input logic [AW-1:0] a, input logic clr,
                           input logic [31:0] e32, input logic [11:0] es, input logic [11:0] ew);
        host_vld  = 1'b1;
        host_addr = a;
        host_clr  = clr;
        #1;
        check($sformatf("host_rdy[%0d]", a), host_rdy, 1'b1);
        tick();
        host_vld = 1'b0;
        host_clr = 1'b0;
        check($sformatf("rd_vld[%0d]", a), host_rd_vld, 1'b1);
        check($sformatf("rd_data32[%0d]", a), host_rd_data, e32);
        check($sformatf("rd_sat12[%0d]", a), s_host_rd_data, es);
        check($sformatf("rd_wrap12[%0d]", a), w_host_rd_data, ew);
    endtask

    // Sweep is 64 cycles from the first edge after reset/soft_clr release.
    task automatic wait_sweep(input int already);
        repeat (63 - already) tick();
        check("init_done_early", init_done, 1'b0);
        check("host_rdy_in_init", host_rdy, 1'b0);
        tick();
        check("init_done", init_done, 1'b1);
        check("init_done_s12", s_init_done, 1'b1);
    endtask

    task automatic read_all_zero();
        for (int i = 0; i < 64; i++) begin
            host_rd(6'(i), 1'b0, 32'd0, 12'd0, 12'd0);
        end
    endtask

    initial begin
        int ne;
        int nh;

        // Reset values, readies held low with both valids asserted.
        evt_vld  = 1'b1;
        host_vld = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_init_done", init_done, 1'b0);
        check("rst_rd_vld", host_rd_vld, 1'b0);
        check("rst_rd_data", host_rd_data, 32'd0);
        check("rst_ovf_pulse", ovf_pulse, 1'b0);
        check("rst_ovf_addr", ovf_addr, 6'd0);
        check("rst_evt_rdy", evt_rdy, 1'b0);
        check("rst_host_rdy", host_rdy, 1'b0);
        evt_vld  = 1'b0;
        host_vld = 1'b0;
        rst_n    = 1'b1;
        wait_sweep(0);

        #1;
        check("idle_evt_rdy", evt_rdy, 1'b1);
        check("idle_host_rdy", host_rdy, 1'b1);
        #1;
        tick();
        read_all_zero();

        // Accumulation on consecutive cycles: 3 + 4 + 250 = 257.
        do_evt(6'd5, 8'd3);
        do_evt(6'd5, 8'd4);
        do_evt(6'd5, 8'd250);
        evt_vld = 1'b0;
        host_rd(6'd5, 1'b0, 32'd257, 12'd257, 12'd257);
        tick();
        check("rd_vld_single", host_rd_vld, 1'b0);

        // Preload index 9 to 16*255 = 0xFF0, then add 0x20.
        repeat (16) do_evt(6'd9, 8'd255);
        do_evt(6'd9, 8'h20);
        evt_vld = 1'b0;
        check("ovf32_none", ovf_pulse, 1'b0);
        check("ovf_sat12", s_ovf_pulse, 1'b1);
        check("ovf_addr_sat12", s_ovf_addr, 6'd9);
        check("ovf_wrap12", w_ovf_pulse, 1'b1);
        check("ovf_addr_wrap12", w_ovf_addr, 6'd9);
        tick();
        check("ovf_single", s_ovf_pulse, 1'b0);
        // +1 onto a saturated counter is still an overflow; +0 is not.
        do_evt(6'd9, 8'd1);
        evt_vld = 1'b0;
        check("ovf_sat_again", s_ovf_pulse, 1'b1);
        check("ovf_wrap_noovf", w_ovf_pulse, 1'b0);
        do_evt(6'd9, 8'd0);
        evt_vld = 1'b0;
        check("ovf_sat_zero_inc", s_ovf_pulse, 1'b0);
        host_rd(6'd9, 1'b0, 32'h1011, 12'hFFF, 12'h011);

        // Clear-on-read, then an event right after a clear.
        do_evt(6'd2, 8'd7);
        evt_vld = 1'b0;
        host_rd(6'd2, 1'b1, 32'd7, 12'd7, 12'd7);
        host_rd(6'd2, 1'b0, 32'd0, 12'd0, 12'd0);
        do_evt(6'd2, 8'd7);
        evt_vld = 1'b0;
        host_rd(6'd2, 1'b1, 32'd7, 12'd7, 12'd7);
        do_evt(6'd2, 8'd5);
        evt_vld = 1'b0;
        host_rd(6'd2, 1'b0, 32'd5, 12'd5, 12'd5);

        // soft_clr mid-stream with a host read in flight.
        do_evt(6'd3, 8'd1);
        do_evt(6'd3, 8'd1);
        evt_vld   = 1'b0;
        host_vld  = 1'b1;
        host_addr = 6'd5;
        #1;
        check("pre_clr_host_rdy", host_rdy, 1'b1);
        tick();
        evt_vld  = 1'b1;
        soft_clr = 1'b1;
        #1;
        check("clr_evt_rdy", evt_rdy, 1'b0);
        check("clr_host_rdy", host_rdy, 1'b0);
        check("inflight_rd_vld", host_rd_vld, 1'b1);
        check("inflight_rd_data", host_rd_data, 32'd257);
        tick();
        soft_clr = 1'b0;
        #1;
        check("clr_init_done", init_done, 1'b0);
        check("clr_sweep_evt_rdy", evt_rdy, 1'b0);
        check("clr_no_rd", host_rd_vld, 1'b0);
        evt_vld  = 1'b0;
        host_vld = 1'b0;

        // Reset mid-sweep restarts the sweep from zero.
        repeat (20) tick();
        rst_n = 1'b0;
        #1;
        check("midsweep_rst_init", init_done, 1'b0);
        check("midsweep_rst_evt_rdy", evt_rdy, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        wait_sweep(0);
        read_all_zero();

        // Contention: events first after the sweep, then strict alternation.
        tick();
        evt_vld   = 1'b1;
        evt_addr  = 6'd1;
        evt_inc   = 8'd1;
        host_vld  = 1'b1;
        host_addr = 6'd1;
        host_clr  = 1'b0;
        ne = 0;
        nh = 0;
        for (int j = 0; j < 10; j++) begin
            #1;
            check($sformatf("rr_evt_rdy%0d", j), evt_rdy, (j % 2) == 0);
            check($sformatf("rr_host_rdy%0d", j), host_rdy, (j % 2) == 1);
            check($sformatf("rr_rd_vld%0d", j), host_rd_vld, (j > 0) && ((j % 2) == 0));
            if ((j > 0) && ((j % 2) == 0)) begin
                check($sformatf("rr_rd_data%0d", j), host_rd_data, 32'(j / 2));
            end
            ne += int'(evt_rdy);
            nh += int'(host_rdy);
            tick();
        end
        evt_vld  = 1'b0;
        host_vld = 1'b0;
        check("rr_last_rd_vld", host_rd_vld, 1'b1);
        check("rr_last_rd_data", host_rd_data, 32'd5);
        check("rr_evt_grants", 32'(ne), 32'd5);
        check("rr_host_grants", 32'(nh), 32'd5);
        host_rd(6'd1, 1'b0, 32'd5, 12'd5, 12'd5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
        $fatal(1, "timeout");
    end

endmodule
